// File: rtl/key_search_pkg.sv
// Shared types and constants for the ARC4 key search block and its
// plaintext monitor.
package key_search_pkg;

  localparam int         KEY_W    = 24;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    ARST,
    START,
    WAIT,
    CHECK,
    DONE
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/key_search_pt_check.sv
// Snoops the arc4 plaintext write port and latches a sticky "bad" flag on any
// non-printable byte written past the length byte at address 0.
module pt_check
  import key_search_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_snoop,
  input  logic [7:0] i_pt_addr,
  input  logic [7:0] i_pt_wrdata,
  input  logic       i_pt_wren,
  output logic       o_bad
);

  logic r_bad;
  logic w_hit;

  assign w_hit = i_snoop && i_pt_wren && (i_pt_addr != 8'd0)
                 && !is_printable(i_pt_wrdata);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bad <= 1'b0;
    end else if (i_clear) begin
      r_bad <= 1'b0;
    end else if (w_hit) begin
      r_bad <= 1'b1;
    end
  end

  assign o_bad = r_bad;

endmodule

// File: rtl/key_search.sv
// Brute-force key search: restarts an arc4 instance with successive keys until
// the decrypted plaintext is entirely printable or the key space is exhausted.
module key_search
  import key_search_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_FIRST = 24'h000000,
  parameter int unsigned      KEY_STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             a4_rst_n,
  output logic             a4_en,
  input  logic             a4_rdy,
  output logic [KEY_W-1:0] a4_key,
  input  logic [7:0]       a4_pt_addr,
  input  logic [7:0]       a4_pt_wrdata,
  input  logic             a4_pt_wren
);

  // arc4 drops rdy one cycle after sampling a4_en, so WAIT must ignore the
  // stale rdy it still sees right after START.
  localparam logic [1:0] WAIT_MIN = 2'd2;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] w_key_nxt;
  logic             r_key_valid;
  logic             w_key_valid_nxt;
  logic             r_a4_en;
  logic             w_a4_en_nxt;
  logic             r_rdy;
  logic             w_rdy_nxt;
  logic [1:0]       r_wait_cnt;
  logic [1:0]       w_wait_cnt_nxt;
  logic             w_clear;
  logic             w_snoop;
  logic             w_bad;
  logic [KEY_W:0]   w_key_sum;
  logic             w_wrap;

  assign w_key_sum = {1'b0, r_key} + (KEY_W + 1)'(KEY_STEP);
  assign w_wrap    = w_key_sum[KEY_W];
  assign w_snoop   = (r_state == START) || (r_state == WAIT);

  pt_check u_pt_check (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_snoop    (w_snoop),
    .i_pt_addr  (a4_pt_addr),
    .i_pt_wrdata(a4_pt_wrdata),
    .i_pt_wren  (a4_pt_wren),
    .o_bad      (w_bad)
  );

  // State and registered outputs; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_key       <= KEY_FIRST;
      r_key_valid <= 1'b0;
      r_a4_en     <= 1'b0;
      r_rdy       <= 1'b1;
      r_wait_cnt  <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_key       <= w_key_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_a4_en     <= w_a4_en_nxt;
      r_rdy       <= w_rdy_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (en) w_state_nxt = ARST;
      ARST:       w_state_nxt = START;
      START:      if (a4_rdy) w_state_nxt = WAIT;
      WAIT:       if (a4_rdy && (r_wait_cnt == WAIT_MIN)) w_state_nxt = CHECK;
      CHECK:      w_state_nxt = (!w_bad || w_wrap) ? DONE : ARST;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_key_nxt       = r_key;
    w_key_valid_nxt = r_key_valid;
    w_clear         = 1'b0;
    w_wait_cnt_nxt  = 2'd0;
    case (r_state)
      IDLE, DONE: begin
        if (en) begin
          w_key_nxt       = KEY_FIRST;
          w_key_valid_nxt = 1'b0;
          w_clear         = 1'b1;
        end
      end
      WAIT: begin
        w_wait_cnt_nxt = (r_wait_cnt == WAIT_MIN) ? r_wait_cnt : r_wait_cnt + 2'd1;
      end
      CHECK: begin
        if (!w_bad) begin
          w_key_valid_nxt = 1'b1;
        end else if (w_wrap) begin
          w_key_valid_nxt = 1'b0;
        end else begin
          w_key_nxt = w_key_sum[KEY_W-1:0];
          w_clear   = 1'b1;
        end
      end
      default: ;
    endcase
    w_a4_en_nxt = (r_state == START) && a4_rdy;
    w_rdy_nxt   = (w_state_nxt == IDLE) || (w_state_nxt == DONE);
  end

  assign rdy       = r_rdy;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign a4_en     = r_a4_en;
  assign a4_key    = r_key;
  // Combinational so arc4 is held in reset in the same cycle as this block.
  assign a4_rst_n  = reset && (r_state != ARST);

endmodule

// File: tb/tb_key_search.sv
// Directed bench: several key_search instances, each paired with a small
// behavioural arc4 that writes a fixed plaintext which is printable only for
// one chosen key.
module tb_key_search;
  import key_search_pkg::*;

  localparam int NI = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] reset_r;
  logic [NI-1:0] en_r;
  logic [NI-1:0] rdy_w, key_valid_w, a4_rst_n_w, a4_en_w, a4_rdy_w, pt_wren_w, busy_w;
  logic [23:0]   key_w    [NI];
  logic [23:0]   a4_key_w [NI];
  logic [7:0]    pt_addr_w[NI];
  logic [7:0]    pt_data_w[NI];
  int            arst_w   [NI];
  int            a4en_w   [NI];
  int            keymis_w [NI];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [23:0] first_of(input int g);
    case (g)
      0:       return 24'h000000;
      1:       return 24'hFFFFF0;
      2:       return 24'hFFFFFF;
      3:       return 24'h000000;
      4:       return 24'hFFFFF1;
      5:       return 24'hFFFFF0;
      default: return 24'h000001;
    endcase
  endfunction

  function automatic int step_of(input int g);
    return (g <= 2) ? 1 : 2;
  endfunction

  function automatic logic [23:0] answer_of(input int g);
    case (g)
      0:       return 24'h000018;
      1, 2:    return 24'h800000;
      default: return 24'h000004;
    endcase
  endfunction

  // Plaintext {len, "HELLO"}; instance 3 uses a non-printable length byte and
  // the printable edge values 8'h20 / 8'h7E. Wrong keys corrupt byte 3.
  function automatic logic [7:0] pt_byte(input int g, input logic [23:0] k,
                                         input logic [2:0] idx);
    logic [7:0] msg [6];
    if (g == 3) msg = '{8'h00, 8'h48, 8'h20, 8'h4C, 8'h7E, 8'h4F};
    else        msg = '{8'h05, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    if (k != answer_of(g)) msg[3] = k[0] ? 8'h7F : 8'h1F;
    return (idx < 3'd6) ? msg[idx] : 8'h00;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    key_search #(.KEY_FIRST(first_of(g)), .KEY_STEP(step_of(g))) dut (
      .clk         (clk),
      .reset       (reset_r[g]),
      .en          (en_r[g]),
      .rdy         (rdy_w[g]),
      .key         (key_w[g]),
      .key_valid   (key_valid_w[g]),
      .a4_rst_n    (a4_rst_n_w[g]),
      .a4_en       (a4_en_w[g]),
      .a4_rdy      (a4_rdy_w[g]),
      .a4_key      (a4_key_w[g]),
      .a4_pt_addr  (pt_addr_w[g]),
      .a4_pt_wrdata(pt_data_w[g]),
      .a4_pt_wren  (pt_wren_w[g])
    );

    logic        m_rdy, m_busy, m_wren;
    logic [2:0]  m_idx;
    logic [23:0] m_key;
    logic [7:0]  m_addr, m_data;
    int          arst_cnt = 0;
    int          a4en_cnt = 0;
    int          keymis   = 0;

    always @(posedge clk) begin
      if (!a4_rst_n_w[g]) begin
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
        m_wren <= 1'b0;
        m_idx  <= 3'd0;
        m_addr <= 8'd0;
        m_data <= 8'd0;
      end else if (m_rdy && a4_en_w[g]) begin
        m_rdy  <= 1'b0;
        m_busy <= 1'b1;
        m_idx  <= 3'd0;
        m_key  <= a4_key_w[g];
      end else if (m_busy) begin
        m_wren <= 1'b1;
        m_addr <= {5'd0, m_idx};
        m_data <= pt_byte(g, m_key, m_idx);
        m_idx  <= m_idx + 3'd1;
        if (m_idx == 3'd5) m_busy <= 1'b0;
      end else begin
        m_wren <= 1'b0;
        m_rdy  <= 1'b1;
      end
      if (reset_r[g] && !a4_rst_n_w[g]) arst_cnt <= arst_cnt + 1;
      if (a4_en_w[g])                   a4en_cnt <= a4en_cnt + 1;
      if (a4_key_w[g] !== key_w[g])     keymis   <= keymis + 1;
    end

    assign a4_rdy_w[g]  = m_rdy;
    assign busy_w[g]    = m_busy;
    assign pt_wren_w[g] = m_wren;
    assign pt_addr_w[g] = m_addr;
    assign pt_data_w[g] = m_data;
    assign arst_w[g]    = arst_cnt;
    assign a4en_w[g]    = a4en_cnt;
    assign keymis_w[g]  = keymis;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic run_search(input int g, input int exp_att, input logic [23:0] exp_key,
                            input logic exp_valid, input bit poke);
    int a0, e0;
    bit done, poked;
    logic [23:0] k_done;
    a0 = arst_w[g];
    e0 = a4en_w[g];
    done  = 1'b0;
    poked = 1'b0;
    @(negedge clk); en_r[g] = 1'b1;
    @(negedge clk); en_r[g] = 1'b0;
    check($sformatf("i%0d rdy low after en", g), rdy_w[g], 1'b0);
    for (int c = 0; c < 5000 && !done; c++) begin
      if (rdy_w[g]) begin
        done = 1'b1;
      end else begin
        if (poke && !poked && busy_w[g] && (arst_w[g] - a0 == 2)) begin
          en_r[g] = 1'b1;
          poked   = 1'b1;
        end
        @(negedge clk);
        en_r[g] = 1'b0;
      end
    end
    check($sformatf("i%0d search finished", g), done, 1'b1);
    check($sformatf("i%0d attempts", g), arst_w[g] - a0, exp_att);
    check($sformatf("i%0d a4_en pulses", g), a4en_w[g] - e0, exp_att);
    check($sformatf("i%0d key", g), key_w[g], exp_key);
    check($sformatf("i%0d key_valid", g), key_valid_w[g], exp_valid);
    k_done = key_w[g];
    repeat (5) @(negedge clk);
    check($sformatf("i%0d key stable in DONE", g), key_w[g], k_done);
    check($sformatf("i%0d key_valid stable in DONE", g), key_valid_w[g], exp_valid);
    check($sformatf("i%0d rdy in DONE", g), rdy_w[g], 1'b1);
    check($sformatf("i%0d a4_en idle in DONE", g), a4_en_w[g], 1'b0);
  endtask

  initial begin
    int a0;
    reset_r = '0;
    en_r    = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("i%0d reset rdy", g), rdy_w[g], 1'b1);
      check($sformatf("i%0d reset key", g), key_w[g], first_of(g));
      check($sformatf("i%0d reset key_valid", g), key_valid_w[g], 1'b0);
      check($sformatf("i%0d reset a4_en", g), a4_en_w[g], 1'b0);
      check($sformatf("i%0d reset a4_rst_n", g), a4_rst_n_w[g], 1'b0);
    end
    reset_r = '1;
    @(negedge clk);
    check("i0 a4_rst_n idle", a4_rst_n_w[0], 1'b1);

    // Reset during WAIT of attempt 3 abandons the search.
    a0 = arst_w[0];
    en_r[0] = 1'b1;
    @(negedge clk); en_r[0] = 1'b0;
    for (int c = 0; c < 2000 && !((arst_w[0] - a0 == 3) && busy_w[0]); c++) @(negedge clk);
    check("i0 reached attempt 3", arst_w[0] - a0, 3);
    check("i0 attempt 3 key", key_w[0], 24'h000002);
    reset_r[0] = 1'b0;
    #1;
    check("i0 a4_rst_n follows reset", a4_rst_n_w[0], 1'b0);
    @(negedge clk);
    check("i0 mid reset rdy", rdy_w[0], 1'b1);
    check("i0 mid reset key", key_w[0], 24'h000000);
    check("i0 mid reset key_valid", key_valid_w[0], 1'b0);
    check("i0 mid reset a4_en", a4_en_w[0], 1'b0);
    reset_r[0] = 1'b1;
    @(negedge clk);

    run_search(0, 25, 24'h000018, 1'b1, 1'b1);
    run_search(0, 25, 24'h000018, 1'b1, 1'b0);
    run_search(1, 16, 24'hFFFFFF, 1'b0, 1'b0);
    run_search(2, 1,  24'hFFFFFF, 1'b0, 1'b0);
    run_search(3, 3,  24'h000004, 1'b1, 1'b0);
    run_search(4, 8,  24'hFFFFFF, 1'b0, 1'b0);
    run_search(5, 8,  24'hFFFFFE, 1'b0, 1'b0);

    // Odd keys with step 2 never hit the even answer; sample attempt 20.
    a0 = arst_w[6];
    en_r[6] = 1'b1;
    @(negedge clk); en_r[6] = 1'b0;
    for (int c = 0; c < 3000 && !((arst_w[6] - a0 == 20) && busy_w[6]); c++) @(negedge clk);
    check("i6 reached attempt 20", arst_w[6] - a0, 20);
    check("i6 still searching", rdy_w[6], 1'b0);
    check("i6 key_valid low", key_valid_w[6], 1'b0);
    check("i6 attempt 20 key", key_w[6], 24'h000027);
    reset_r[6] = 1'b0;
    @(negedge clk);
    reset_r[6] = 1'b1;

    for (int g = 0; g < NI; g++) check($sformatf("i%0d a4_key tracks key", g), keymis_w[g], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
